// File: rtl/line_fill_responder.sv
// Instruction-cache line-fill responder: 16 handshaked 32-bit RAM reads assembled into one 512-bit line.
// Optional one-line reuse buffer enabled by defining LINE_FILL_BUF_EN.
module line_fill_responder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_addr_valid,
  input  logic [31:0]  mem_addr,
  output logic         mem_data_ready,
  output logic [511:0] mem_data_o,
  output logic         ram_req,
  output logic [31:0]  ram_addr,
  input  logic         ram_ack,
  input  logic [31:0]  ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_t;

  state_t         r_state;
  logic [25:0]    r_line;
  logic [3:0]     r_beat;
  logic           r_abort;
  logic           r_ready;
  logic [511:0]   r_data;
  logic           r_req;
  logic [31:0]    r_addr;

  logic           w_mismatch;
  logic           w_ack;
  logic           w_hit;
  logic           w_fill_done;

  // Any cycle where the cache no longer wants this exact line poisons the fetch.
  assign w_mismatch  = !mem_addr_valid || (mem_addr[31:6] != r_line);
  assign w_ack       = r_req && ram_ack;
  assign w_fill_done = (r_state == S_FETCH) && w_ack && (r_beat == 4'd15) &&
                       !r_abort && !w_mismatch;

`ifdef LINE_FILL_BUF_EN
  logic [25:0]    r_buf_line;
  logic           r_buf_valid;

  assign w_hit = r_buf_valid && (mem_addr[31:6] == r_buf_line);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf_line  <= '0;
    end else if ((r_state == S_IDLE) && mem_addr_valid && !w_hit) begin
      r_buf_valid <= 1'b0;
    end else if (w_fill_done) begin
      r_buf_valid <= 1'b1;
      r_buf_line  <= r_line;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_line  <= '0;
      r_beat  <= '0;
      r_abort <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_addr_valid) begin
            r_line  <= mem_addr[31:6];
            r_beat  <= '0;
            r_abort <= 1'b0;
            if (w_hit) begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_FETCH;
              r_req   <= 1'b1;
              r_addr  <= {mem_addr[31:6], 4'd0, 2'b00};
            end
          end
        end
        S_FETCH: begin
          if (w_ack) begin
            r_data[{r_beat, 5'd0} +: 32] <= ram_rdata;
            if (r_abort || w_mismatch) begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end else if (r_beat == 4'd15) begin
              r_state <= S_RESP;
              r_req   <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_beat <= r_beat + 4'd1;
              r_addr <= {r_line, r_beat + 4'd1, 2'b00};
            end
          end else if (w_mismatch) begin
            r_abort <= 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_data_ready = r_ready;
  assign mem_data_o     = r_data;
  assign ram_req        = r_req;
  assign ram_addr       = r_addr;

endmodule

// File: doc/line_fill_responder.md
# line_fill_responder

Memory-side responder for the instruction cache's line-fill port. Accepts a line-miss request (`mem_addr_valid`/`mem_addr`), reads the 64-byte line from a 32-bit word-wide backing RAM as 16 sequential handshaked beats, and returns the whole line on a 512-bit bus with a one-cycle `mem_data_ready` pulse. It sits between the cache and the backing memory and keeps at most one RAM request outstanding.

## Interface
- No parameters. Line size is fixed at 16 words, 512 bits, and addresses are 32 bits.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_addr_valid`  in  1  cache requests a line fill.
- `mem_addr`  in  32  miss address; bits [31:6] select the line, bits [5:0] are ignored.
- `mem_data_ready`  out  1  one-cycle pulse: `mem_data_o` holds the requested line.
- `mem_data_o`  out  512  line data, registered; word *i* is at [32i+31:32i].
- `ram_req`  out  1  word read request; held until acknowledged.
- `ram_addr`  out  32  byte address of the requested word; bits [1:0] are always 0.
- `ram_ack`  in  1  RAM has accepted the request, and `ram_rdata` is valid in the same cycle.
- `ram_rdata`  in  32  read data.

## Operation
- The FSM has three states: IDLE, FETCH and RESP.
- **IDLE:**
  - On a sampled `mem_addr_valid` = 1, latch `line` = `mem_addr[31:6]`, clear the beat counter `beat` (4 bits) and `abort`, then go to FETCH.
  - `ram_ack` is ignored in IDLE.
- **FETCH:**
  - `ram_req` = 1 and `ram_addr` = {line, beat, 2'b00}.
  - On `ram_ack`, write `ram_rdata` into word `beat` of `mem_data_o`.
  - If `beat` = 15, go to RESP, or to IDLE when `abort` is set. Otherwise increment `beat` and keep `ram_req` high with the next address.
- **Abort:**
  - During FETCH, any sampled cycle with `mem_addr_valid` = 0 or `mem_addr[31:6]` ≠ `line` sets `abort`.
  - With `abort` set, the next `ram_ack` completes the current beat, then the FSM goes to IDLE without raising `ram_req` again and without a response.
- **RESP:**
  - `mem_data_ready` = 1 for exactly one cycle, then return to IDLE.
  - The pulse is issued only if the request is still valid and matches `line`. Otherwise the FSM goes to IDLE silently.
- **Data hold:** `mem_data_o` changes only on FETCH acks and on reset. It is stable from RESP until the next fetch's first ack.
- **Request drop after a fill:** the cache drops `mem_addr_valid` the cycle after the pulse. IDLE must sample it low and not re-fetch.

## Timing
- **Reset values:** asynchronous assertion forces IDLE and sets `ram_req`=0, `ram_addr`=0, `mem_data_ready`=0, `mem_data_o`=0 and `beat`=0. The line buffer is marked invalid.
- **Reset mid-FETCH:** the outstanding RAM request is abandoned, and any later `ram_ack` is ignored.
- **Handshake:** `ram_req` and `ram_addr` are registered outputs and are stable while `ram_req` is high and `ram_ack` is low. `ram_ack` is honoured only while `ram_req` = 1.
- **Zero-wait RAM latency** (ack in the same cycle as request), with the request sampled at edge E0:
  - `ram_req` rises after E0.
  - Beat *i* is acked in cycle *i*+1.
  - `mem_data_ready` is high in cycle 17.
  - Total: 17 cycles from request to ready.
- **Wait states:** each cycle of RAM delay adds one cycle of latency per beat.
- **Response:** `mem_data_ready` is never high for two consecutive cycles.

## Configuration
- **`LINE_FILL_BUF_EN` defined:** `mem_data_o` doubles as a one-line buffer tagged with `buf_line`/`buf_valid`.
  - `buf_valid` clears when a FETCH starts, and sets with `buf_line` = `line` on entry to RESP.
  - Buffer hit: an IDLE request whose `mem_addr[31:6]` = `buf_line` with `buf_valid` = 1 goes straight to RESP. `mem_data_ready` is high the cycle after the request, with zero RAM traffic.
  - An aborted fetch leaves `buf_valid` = 0.
- **`LINE_FILL_BUF_EN` undefined:** there is no buffer logic, and every request performs a 16-beat fetch.

## Test plan
- **Basic fill:** reset, then a RAM returning `ram_rdata` = `ram_addr` with zero wait; request 0x0000_1234.
  - `ram_addr` steps through 0x1200, 0x1204, … 0x123C.
  - `mem_data_ready` pulses in cycle 17.
  - `mem_data_o[31:0]` = 0x1200 and `[511:480]` = 0x123C.
- **Wait states:** same request with `ram_ack` delayed 3 cycles per beat.
  - `ram_addr` is held stable while waiting.
  - Ready arrives 17 + 48 = 65 cycles after the request.
- **Abort:** drop `mem_addr_valid` at beat 5.
  - Beat 5 completes.
  - `ram_req` is low afterwards.
  - No `mem_data_ready` pulse occurs, and the FSM is back in IDLE.
- **Reset mid-FETCH:** assert `rst_n` low at beat 9.
  - All outputs go to zero immediately.
  - A stray `ram_ack` afterwards is ignored.
  - A new request then fills correctly from beat 0.
- **Buffer hit, with `LINE_FILL_BUF_EN`:** fill 0x1200, then request 0x1210.
  - Ready arrives one cycle after the request, with no `ram_req`.
  - A request for 0x2200 still performs a full fetch.
- **Back-to-back requests:** the cache drops its request after the pulse, then raises 0x4000.
  - Exactly one fetch is performed per request.
  - There is no duplicate pulse.
